// File: rtl/pc_src_ctrl_if.sv
// Bundle between the PC sequencer and its surroundings: request inputs, the PC-source mux
// select/vector, and the architectural PC/EPC state.
interface pc_src_ctrl_if;
    logic        Stall;
    logic        JumpReq;
    logic        BranchReq;
    logic        BranchCond;
    logic        IntReq;
    logic        IRet;
    logic [15:0] NextPC;
    logic [1:0]  PCSrc;
    logic [15:0] VecAddr;
    logic [15:0] PC;
    logic [15:0] EPC;
    logic        IntAck;
    logic        Flush;
    logic        InISR;
    logic        AlignErr;

    // Environment side: issues requests and closes the mux loop via NextPC.
    modport master (
        output Stall, JumpReq, BranchReq, BranchCond, IntReq, IRet, NextPC,
        input  PCSrc, VecAddr, PC, EPC, IntAck, Flush, InISR, AlignErr
    );

    // Sequencer side.
    modport slave (
        input  Stall, JumpReq, BranchReq, BranchCond, IntReq, IRet, NextPC,
        output PCSrc, VecAddr, PC, EPC, IntAck, Flush, InISR, AlignErr
    );
endinterface

// File: rtl/pc_src_ctrl.sv
// PC sequencer: owns PC/EPC and drives the 4:1 PC-source mux select (PC+2 adder lives outside).
// Optional macro PC_ALIGN_CHK_EN builds the sticky odd-PC AlignErr flag; otherwise AlignErr=0.
module pc_src_ctrl #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] INT_VECTOR = 16'h0010
) (
    input  logic               CLK,
    input  logic               Reset_n,
    pc_src_ctrl_if.slave       bus
);

    localparam int unsigned AW = 16;

    localparam logic [1:0] S_HOLD = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_ISR  = 2'b10;

    localparam logic [1:0] SRC_SEQ = 2'd0;
    localparam logic [1:0] SRC_BR  = 2'd1;
    localparam logic [1:0] SRC_JMP = 2'd2;
    localparam logic [1:0] SRC_VEC = 2'd3;

    logic [1:0]    r_state;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_epc;
    logic          r_int_ack;
    logic          r_flush;

    logic [1:0]    w_next_state;
    logic [1:0]    w_pcsrc;
    logic [AW-1:0] w_vec_addr;
    logic          w_int_accept;
    logic          w_redirect;

    assign w_redirect = bus.JumpReq | (bus.BranchReq & bus.BranchCond);

    // Select priority: jump > taken branch > interrupt entry / return > sequential.
    always_comb begin
        w_next_state = r_state;
        w_pcsrc      = SRC_SEQ;
        w_vec_addr   = INT_VECTOR;
        w_int_accept = 1'b0;
        case (r_state)
            S_HOLD: begin
                w_next_state = S_RUN;
            end
            S_RUN: begin
                if (bus.JumpReq) begin
                    w_pcsrc = SRC_JMP;
                end else if (bus.BranchReq && bus.BranchCond) begin
                    w_pcsrc = SRC_BR;
                end else if (bus.IntReq) begin
                    w_pcsrc      = SRC_VEC;
                    w_int_accept = 1'b1;
                    w_next_state = S_ISR;
                end
            end
            S_ISR: begin
                w_vec_addr = r_epc;
                if (bus.JumpReq) begin
                    w_pcsrc = SRC_JMP;
                end else if (bus.BranchReq && bus.BranchCond) begin
                    w_pcsrc = SRC_BR;
                end else if (bus.IRet && !w_redirect) begin
                    w_pcsrc      = SRC_VEC;
                    w_next_state = S_RUN;
                end
            end
            default: begin
                w_next_state = S_HOLD;
            end
        endcase
    end

    // HOLD advances unconditionally; elsewhere Stall freezes everything except the ack pulse.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_HOLD;
            r_pc      <= RESET_PC;
            r_epc     <= '0;
            r_int_ack <= 1'b0;
            r_flush   <= 1'b0;
        end else if (r_state == S_HOLD) begin
            r_state   <= w_next_state;
            r_int_ack <= 1'b0;
        end else if (!bus.Stall) begin
            r_state   <= w_next_state;
            r_pc      <= bus.NextPC;
            r_int_ack <= w_int_accept;
            r_flush   <= (w_pcsrc != SRC_SEQ);
            if (w_int_accept) begin
                r_epc <= r_pc;
            end
        end else begin
            r_int_ack <= 1'b0;
        end
    end

`ifdef PC_ALIGN_CHK_EN
    logic r_align_err;

    // Sticky until reset; the odd value is still written into PC.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_align_err <= 1'b0;
        end else if ((r_state != S_HOLD) && !bus.Stall && bus.NextPC[0]) begin
            r_align_err <= 1'b1;
        end
    end

    assign bus.AlignErr = r_align_err;
`else
    assign bus.AlignErr = 1'b0;
`endif

    assign bus.PCSrc   = w_pcsrc;
    assign bus.VecAddr = w_vec_addr;
    assign bus.PC      = r_pc;
    assign bus.EPC     = r_epc;
    assign bus.IntAck  = r_int_ack;
    assign bus.Flush   = r_flush;
    assign bus.InISR   = (r_state == S_ISR);

endmodule

// File: tb/tb_pc_src_ctrl.sv
// Directed bench for pc_src_ctrl; closes the external PC-source mux around the DUT.
module tb_pc_src_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] br_tgt;
    logic [15:0] jmp_tgt;
    int          total;
    int          bad;

    pc_src_ctrl_if bus ();

    pc_src_ctrl #(
        .RESET_PC   (16'h0000),
        .INT_VECTOR (16'h0010)
    ) dut (
        .CLK     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    // External mux and PC+2 adder.
    always_comb begin
        case (bus.PCSrc)
            2'd0:    bus.NextPC = bus.PC + 16'd2;
            2'd1:    bus.NextPC = br_tgt;
            2'd2:    bus.NextPC = jmp_tgt;
            default: bus.NextPC = bus.VecAddr;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.Stall = 1'b0; bus.JumpReq = 1'b0; bus.BranchReq = 1'b0; bus.BranchCond = 1'b0;
        bus.IntReq = 1'b0; bus.IRet = 1'b0; br_tgt = 16'h0000; jmp_tgt = 16'h0000;
        #12;
        total++; if (bus.PC !== 16'h0000) begin bad++; $display("FAIL rst_pc got=%h exp=%h", bus.PC, 16'h0000); end
        total++; if (bus.EPC !== 16'h0000) begin bad++; $display("FAIL rst_epc got=%h exp=%h", bus.EPC, 16'h0000); end
        total++; if ({bus.Flush, bus.IntAck, bus.InISR, bus.AlignErr} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b exp=%b", {bus.Flush, bus.IntAck, bus.InISR, bus.AlignErr}, 4'b0000); end
        total++; if (bus.PCSrc !== 2'd0) begin bad++; $display("FAIL rst_pcsrc got=%0d exp=%0d", bus.PCSrc, 0); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (bus.PC !== 16'h0000) begin bad++; $display("FAIL hold_pc got=%h exp=%h", bus.PC, 16'h0000); end
        tick();
        total++; if (bus.PC !== 16'h0002) begin bad++; $display("FAIL seq_pc2 got=%h exp=%h", bus.PC, 16'h0002); end
        total++; if (bus.Flush !== 1'b0) begin bad++; $display("FAIL seq_flush got=%b exp=%b", bus.Flush, 1'b0); end
        tick();
        total++; if (bus.PC !== 16'h0004) begin bad++; $display("FAIL seq_pc4 got=%h exp=%h", bus.PC, 16'h0004); end
        total++; if (bus.PCSrc !== 2'd0) begin bad++; $display("FAIL seq_pcsrc got=%0d exp=%0d", bus.PCSrc, 0); end
    endtask

    task automatic test_jump();
        jmp_tgt = 16'h0100; bus.JumpReq = 1'b1;
        #1;
        total++; if (bus.PCSrc !== 2'd2) begin bad++; $display("FAIL jmp_pcsrc got=%0d exp=%0d", bus.PCSrc, 2); end
        tick();
        bus.JumpReq = 1'b0;
        total++; if (bus.PC !== 16'h0100) begin bad++; $display("FAIL jmp_pc got=%h exp=%h", bus.PC, 16'h0100); end
        total++; if (bus.Flush !== 1'b1) begin bad++; $display("FAIL jmp_flush got=%b exp=%b", bus.Flush, 1'b1); end
        tick();
        total++; if (bus.PC !== 16'h0102) begin bad++; $display("FAIL jmp_after_pc got=%h exp=%h", bus.PC, 16'h0102); end
        total++; if (bus.Flush !== 1'b0) begin bad++; $display("FAIL jmp_flush_clr got=%b exp=%b", bus.Flush, 1'b0); end
    endtask

    task automatic test_branch();
        br_tgt = 16'h0080; bus.BranchReq = 1'b1; bus.BranchCond = 1'b0;
        #1;
        total++; if (bus.PCSrc !== 2'd0) begin bad++; $display("FAIL br_nt_pcsrc got=%0d exp=%0d", bus.PCSrc, 0); end
        tick();
        total++; if (bus.PC !== 16'h0104) begin bad++; $display("FAIL br_nt_pc got=%h exp=%h", bus.PC, 16'h0104); end
        bus.BranchCond = 1'b1;
        #1;
        total++; if (bus.PCSrc !== 2'd1) begin bad++; $display("FAIL br_t_pcsrc got=%0d exp=%0d", bus.PCSrc, 1); end
        tick();
        bus.BranchReq = 1'b0; bus.BranchCond = 1'b0;
        total++; if (bus.PC !== 16'h0080) begin bad++; $display("FAIL br_t_pc got=%h exp=%h", bus.PC, 16'h0080); end
        total++; if (bus.Flush !== 1'b1) begin bad++; $display("FAIL br_t_flush got=%b exp=%b", bus.Flush, 1'b1); end
        tick();
        total++; if (bus.PC !== 16'h0082) begin bad++; $display("FAIL br_after_pc got=%h exp=%h", bus.PC, 16'h0082); end
    endtask

    task automatic test_int_vs_jump();
        jmp_tgt = 16'h0200; bus.JumpReq = 1'b1; bus.IntReq = 1'b1;
        #1;
        total++; if (bus.PCSrc !== 2'd2) begin bad++; $display("FAIL ij_pcsrc got=%0d exp=%0d", bus.PCSrc, 2); end
        tick();
        bus.JumpReq = 1'b0;
        total++; if ({bus.PC, bus.IntAck, bus.InISR} !== {16'h0200, 2'b00}) begin bad++; $display("FAIL ij_jump got=%h/%b%b exp=0200/00", bus.PC, bus.IntAck, bus.InISR); end
        #1;
        total++; if ({bus.PCSrc, bus.VecAddr} !== {2'd3, 16'h0010}) begin bad++; $display("FAIL ij_vec got=%0d/%h exp=3/0010", bus.PCSrc, bus.VecAddr); end
        tick();
        bus.IntReq = 1'b0;
        total++; if ({bus.PC, bus.EPC} !== {16'h0010, 16'h0200}) begin bad++; $display("FAIL ij_entry got=%h/%h exp=0010/0200", bus.PC, bus.EPC); end
        total++; if ({bus.IntAck, bus.InISR, bus.Flush} !== 3'b111) begin bad++; $display("FAIL ij_entry_flags got=%b exp=%b", {bus.IntAck, bus.InISR, bus.Flush}, 3'b111); end
        bus.IntReq = 1'b1;
        #1;
        total++; if ({bus.PCSrc, bus.VecAddr} !== {2'd0, 16'h0200}) begin bad++; $display("FAIL isr_ignint got=%0d/%h exp=0/0200", bus.PCSrc, bus.VecAddr); end
        tick();
        bus.IntReq = 1'b0;
        total++; if ({bus.PC, bus.IntAck, bus.Flush, bus.InISR} !== {16'h0012, 3'b001}) begin bad++; $display("FAIL isr_seq got=%h/%b%b%b exp=0012/001", bus.PC, bus.IntAck, bus.Flush, bus.InISR); end
        bus.IRet = 1'b1;
        #1;
        total++; if (bus.PCSrc !== 2'd3) begin bad++; $display("FAIL iret_pcsrc got=%0d exp=%0d", bus.PCSrc, 3); end
        tick();
        total++; if ({bus.PC, bus.InISR, bus.Flush} !== {16'h0200, 2'b01}) begin bad++; $display("FAIL iret got=%h/%b%b exp=0200/01", bus.PC, bus.InISR, bus.Flush); end
        #1;
        total++; if (bus.PCSrc !== 2'd0) begin bad++; $display("FAIL iret_run_ign got=%0d exp=%0d", bus.PCSrc, 0); end
        tick();
        bus.IRet = 1'b0;
        total++; if ({bus.PC, bus.InISR} !== {16'h0202, 1'b0}) begin bad++; $display("FAIL iret_run_pc got=%h/%b exp=0202/0", bus.PC, bus.InISR); end
    endtask

    task automatic test_stall_int();
        bus.Stall = 1'b1; bus.IntReq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.PCSrc !== 2'd3) begin bad++; $display("FAIL stall_pcsrc[%0d] got=%0d exp=%0d", i, bus.PCSrc, 3); end
            tick();
            total++; if ({bus.PC, bus.IntAck, bus.InISR} !== {16'h0202, 2'b00}) begin bad++; $display("FAIL stall_frz[%0d] got=%h/%b%b exp=0202/00", i, bus.PC, bus.IntAck, bus.InISR); end
        end
        bus.Stall = 1'b0;
        tick();
        bus.IntReq = 1'b0;
        total++; if ({bus.PC, bus.EPC, bus.IntAck, bus.InISR} !== {16'h0010, 16'h0202, 2'b11}) begin bad++; $display("FAIL stall_acc got=%h/%h/%b%b exp=0010/0202/11", bus.PC, bus.EPC, bus.IntAck, bus.InISR); end
        bus.Stall = 1'b1;
        tick();
        total++; if ({bus.PC, bus.IntAck, bus.Flush, bus.InISR} !== {16'h0010, 3'b011}) begin bad++; $display("FAIL stall_hold got=%h/%b%b%b exp=0010/011", bus.PC, bus.IntAck, bus.Flush, bus.InISR); end
        bus.Stall = 1'b0;
    endtask

    task automatic test_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({bus.PC, bus.EPC} !== {16'h0000, 16'h0000}) begin bad++; $display("FAIL mrst_regs got=%h/%h exp=0000/0000", bus.PC, bus.EPC); end
        total++; if ({bus.InISR, bus.Flush, bus.IntAck} !== 3'b000) begin bad++; $display("FAIL mrst_flags got=%b exp=%b", {bus.InISR, bus.Flush, bus.IntAck}, 3'b000); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (bus.PC !== 16'h0000) begin bad++; $display("FAIL mrst_hold got=%h exp=%h", bus.PC, 16'h0000); end
        tick();
        total++; if (bus.PC !== 16'h0002) begin bad++; $display("FAIL mrst_run got=%h exp=%h", bus.PC, 16'h0002); end
    endtask

    task automatic test_align();
        logic exp_err;
`ifdef PC_ALIGN_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        jmp_tgt = 16'h0101; bus.JumpReq = 1'b1;
        tick();
        bus.JumpReq = 1'b0;
        total++; if ({bus.PC, bus.AlignErr} !== {16'h0101, exp_err}) begin bad++; $display("FAIL align_set got=%h/%b exp=0101/%b", bus.PC, bus.AlignErr, exp_err); end
        tick();
        tick();
        total++; if ({bus.PC, bus.AlignErr} !== {16'h0105, exp_err}) begin bad++; $display("FAIL align_sticky got=%h/%b exp=0105/%b", bus.PC, bus.AlignErr, exp_err); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_jump();
        test_branch();
        test_int_vs_jump();
        test_stall_int();
        test_reset_mid();
        test_align();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
